// File: rtl/vend_ctrl_param_if.sv
// Handshake/bus bundle between the vending controller, the coin/keypad front end and the dispenser.
// The slave modport is the controller's view; master is the front end / dispenser side.
interface vend_ctrl_param_if #(
    parameter int SEL_W    = 2,
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic [1:0]          coin_val;
    logic                coin_accept;
    logic                coin_reject;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_id;
    logic                cancel;
    logic                err_insuf;
    logic                vend_valid;
    logic [SEL_W-1:0]    vend_id;
    logic                vend_ready;
    logic                chg_valid;
    logic                chg_ready;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_id, cancel, vend_ready, chg_ready,
        output coin_accept, coin_reject, err_insuf, vend_valid, vend_id, chg_valid, credit, busy
    );

    modport master (
        output coin_valid, coin_val, sel_valid, sel_id, cancel, vend_ready, chg_ready,
        input  coin_accept, coin_reject, err_insuf, vend_valid, vend_id, chg_valid, credit, busy
    );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: credit in 0.50 units, per-product price table,
// valid/ready handshakes for product drop and one-coin-per-beat change payout.
module vend_ctrl_param #(
    parameter int                             CREDIT_W    = 4,
    parameter int                             MAX_CREDIT  = 7,
    parameter int                             NUM_PROD    = 4,
    parameter logic [NUM_PROD*CREDIT_W-1:0]   PRICES      = {4'd5, 4'd4, 4'd3, 4'd2},
    parameter bit                             AUTO_CHANGE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    vend_ctrl_param_if.slave   bus
);
    localparam int SEL_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [SEL_W-1:0]    r_vend_id;
    logic                r_coin_accept;
    logic                r_coin_reject;
    logic                r_err_insuf;
    logic                r_vend_valid;
    logic                r_chg_valid;

    state_t              w_state_n;
    logic [CREDIT_W-1:0] w_credit_n;
    logic [SEL_W-1:0]    w_vend_id_n;
    logic                w_accept_n;
    logic                w_reject_n;
    logic                w_err_n;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_ok;

    function automatic logic [1:0] f_coin_units(input logic [1:0] val);
        case (val)
            2'b01:   return 2'd1;
            2'b10:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Sum is formed one bit wider than the credit so a full register can never wrap past the ceiling.
    function automatic logic f_coin_fits(input logic [CREDIT_W-1:0] cr, input logic [1:0] units);
        logic [CREDIT_W:0] sum;
        sum = (CREDIT_W+1)'(cr) + (CREDIT_W+1)'(units);
        return (units != 2'd0) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    endfunction

    function automatic logic [CREDIT_W-1:0] f_price(input logic [SEL_W-1:0] sel);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (int'(sel) == i) p = PRICES[i*CREDIT_W +: CREDIT_W];
        end
        return p;
    endfunction

    assign w_price  = f_price(bus.sel_id);
    assign w_sel_ok = (int'(bus.sel_id) < NUM_PROD) && (r_credit >= w_price);

    always_comb begin
        w_state_n   = r_state;
        w_credit_n  = r_credit;
        w_vend_id_n = r_vend_id;
        w_accept_n  = 1'b0;
        w_reject_n  = 1'b0;
        w_err_n     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // One event per cycle; a coin that loses to cancel or select is handed back.
                if (bus.cancel) begin
                    w_reject_n = bus.coin_valid;
                    if (r_credit != '0) w_state_n = S_CHANGE;
                end else if (bus.sel_valid) begin
                    w_reject_n = bus.coin_valid;
                    if (w_sel_ok) begin
                        w_credit_n  = r_credit - w_price;
                        w_vend_id_n = bus.sel_id;
                        w_state_n   = S_VEND;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (f_coin_fits(r_credit, f_coin_units(bus.coin_val))) begin
                        w_credit_n = r_credit + CREDIT_W'(f_coin_units(bus.coin_val));
                        w_accept_n = 1'b1;
                    end else begin
                        w_reject_n = 1'b1;
                    end
                end
            end
            S_VEND: begin
                w_reject_n = bus.coin_valid;
                if (r_vend_valid && bus.vend_ready)
                    w_state_n = (AUTO_CHANGE && (r_credit != '0)) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                w_reject_n = bus.coin_valid;
                if (r_chg_valid && bus.chg_ready && (r_credit != '0)) begin
                    w_credit_n = r_credit - CREDIT_W'(1);
                    if (r_credit == CREDIT_W'(1)) w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Valids are derived from the next state so they are registered and line up with the state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_vend_id     <= '0;
            r_coin_accept <= 1'b0;
            r_coin_reject <= 1'b0;
            r_err_insuf   <= 1'b0;
            r_vend_valid  <= 1'b0;
            r_chg_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_credit      <= w_credit_n;
            r_vend_id     <= w_vend_id_n;
            r_coin_accept <= w_accept_n;
            r_coin_reject <= w_reject_n;
            r_err_insuf   <= w_err_n;
            r_vend_valid  <= (w_state_n == S_VEND);
            r_chg_valid   <= (w_state_n == S_CHANGE) && (w_credit_n != '0);
        end
    end

    assign bus.coin_accept = r_coin_accept;
    assign bus.coin_reject = r_coin_reject;
    assign bus.err_insuf   = r_err_insuf;
    assign bus.vend_valid  = r_vend_valid;
    assign bus.vend_id     = r_vend_id;
    assign bus.chg_valid   = r_chg_valid;
    assign bus.credit      = r_credit;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: one instance keeps leftover credit, one refunds it automatically;
// both share stimulus and are compared every cycle against a transaction-level reference.
module tb_vend_ctrl_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       c_valid = 1'b0;
    logic [1:0] c_val = 2'd0;
    logic       s_valid = 1'b0;
    logic [1:0] s_id = 2'd0;
    logic       canc = 1'b0;
    logic       v_ready = 1'b0;
    logic       ch_ready = 1'b0;

    vend_ctrl_param_if #(.SEL_W(2), .CREDIT_W(4)) if0 ();
    vend_ctrl_param_if #(.SEL_W(2), .CREDIT_W(4)) if1 ();

    assign if0.coin_valid = c_valid;  assign if1.coin_valid = c_valid;
    assign if0.coin_val   = c_val;    assign if1.coin_val   = c_val;
    assign if0.sel_valid  = s_valid;  assign if1.sel_valid  = s_valid;
    assign if0.sel_id     = s_id;     assign if1.sel_id     = s_id;
    assign if0.cancel     = canc;     assign if1.cancel     = canc;
    assign if0.vend_ready = v_ready;  assign if1.vend_ready = v_ready;
    assign if0.chg_ready  = ch_ready; assign if1.chg_ready  = ch_ready;

    vend_ctrl_param #(.AUTO_CHANGE(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    vend_ctrl_param #(.AUTO_CHANGE(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    int total = 0;
    int bad = 0;

    // Reference: "mode" 0 waiting for customer, 1 product owed, 2 coins owed.
    int price [4] = '{2, 3, 4, 5};
    int m_mode [2] = '{0, 0};
    int m_credit [2] = '{0, 0};
    int m_vid [2] = '{0, 0};
    int m_acc [2] = '{0, 0};
    int m_rej [2] = '{0, 0};
    int m_err [2] = '{0, 0};

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_step();
        int units;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_rej[k] = 0; m_err[k] = 0;
            if (reset) begin
                m_mode[k] = 0; m_credit[k] = 0; m_vid[k] = 0;
            end else if (m_mode[k] == 0) begin
                if (canc) begin
                    m_rej[k] = int'(c_valid);
                    if (m_credit[k] > 0) m_mode[k] = 2;
                end else if (s_valid) begin
                    m_rej[k] = int'(c_valid);
                    if (int'(s_id) < 4 && m_credit[k] >= price[s_id]) begin
                        m_credit[k] -= price[s_id];
                        m_vid[k] = int'(s_id);
                        m_mode[k] = 1;
                    end else m_err[k] = 1;
                end else if (c_valid) begin
                    units = (c_val == 2'b01) ? 1 : (c_val == 2'b10) ? 2 : 0;
                    if (units > 0 && m_credit[k] + units <= 7) begin
                        m_credit[k] += units; m_acc[k] = 1;
                    end else m_rej[k] = 1;
                end
            end else if (m_mode[k] == 1) begin
                m_rej[k] = int'(c_valid);
                if (v_ready) m_mode[k] = (k == 1 && m_credit[k] > 0) ? 2 : 0;
            end else begin
                m_rej[k] = int'(c_valid);
                if (ch_ready) begin
                    m_credit[k] -= 1;
                    if (m_credit[k] == 0) m_mode[k] = 0;
                end
            end
        end
    endtask

    task automatic model_cmp();
        chk("m0_credit", int'(if0.credit), m_credit[0]);
        chk("m0_accept", int'(if0.coin_accept), m_acc[0]);
        chk("m0_reject", int'(if0.coin_reject), m_rej[0]);
        chk("m0_err", int'(if0.err_insuf), m_err[0]);
        chk("m0_vvalid", int'(if0.vend_valid), int'(m_mode[0] == 1));
        chk("m0_vid", int'(if0.vend_id), m_vid[0]);
        chk("m0_cvalid", int'(if0.chg_valid), int'(m_mode[0] == 2));
        chk("m0_busy", int'(if0.busy), int'(m_mode[0] != 0));
        chk("m1_credit", int'(if1.credit), m_credit[1]);
        chk("m1_accept", int'(if1.coin_accept), m_acc[1]);
        chk("m1_reject", int'(if1.coin_reject), m_rej[1]);
        chk("m1_err", int'(if1.err_insuf), m_err[1]);
        chk("m1_vvalid", int'(if1.vend_valid), int'(m_mode[1] == 1));
        chk("m1_vid", int'(if1.vend_id), m_vid[1]);
        chk("m1_cvalid", int'(if1.chg_valid), int'(m_mode[1] == 2));
        chk("m1_busy", int'(if1.busy), int'(m_mode[1] != 0));
        chk("excl_coin", int'(if0.coin_accept & if0.coin_reject) + int'(if1.coin_accept & if1.coin_reject), 0);
        chk("excl_valid", int'(if0.vend_valid & if0.chg_valid) + int'(if1.vend_valid & if1.chg_valid), 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic step(input int cv, input int cval, input int sv, input int sid,
                        input int cn, input int vr, input int cr);
        c_valid = 1'(cv); c_val = 2'(cval); s_valid = 1'(sv); s_id = 2'(sid);
        canc = 1'(cn); v_ready = 1'(vr); ch_ready = 1'(cr);
        tick();
    endtask

    typedef struct {
        int cv, cval, sv, sid, cn, vr, cr;
        int credit, acc, rej, err, vv, vid, cvld, busy;
    } vec_t;
    vec_t tbl [20];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int beats;
        //           cv cval sv sid cn vr cr | credit acc rej err vv vid cvld busy
        tbl[0]  = '{1, 2, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 1, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{1, 2, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{1, 2, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{1, 2, 0, 0, 0, 0, 0,   6, 0, 1, 0, 0, 1, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 0,   7, 1, 0, 0, 0, 1, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 0,   7, 0, 1, 0, 0, 1, 0, 0};
        tbl[11] = '{1, 3, 0, 0, 0, 0, 0,   7, 0, 1, 0, 0, 1, 0, 0};
        tbl[12] = '{0, 0, 1, 3, 0, 0, 0,   2, 0, 0, 0, 1, 3, 0, 1};
        tbl[13] = '{1, 1, 0, 0, 0, 1, 0,   2, 0, 1, 0, 0, 3, 0, 0};
        tbl[14] = '{0, 0, 1, 3, 0, 0, 0,   2, 0, 0, 1, 0, 3, 0, 0};
        tbl[15] = '{1, 1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 0, 1};
        tbl[16] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0};
        tbl[19] = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0};

        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_credit", int'(if0.credit), 0);
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_vvalid", int'(if0.vend_valid), 0);
        chk("rst_cvalid", int'(if0.chg_valid), 0);
        chk("rst_vid", int'(if0.vend_id), 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].cv, tbl[i].cval, tbl[i].sv, tbl[i].sid, tbl[i].cn, tbl[i].vr, tbl[i].cr);
            chk($sformatf("tbl%0d_credit", i), int'(if0.credit), tbl[i].credit);
            chk($sformatf("tbl%0d_accept", i), int'(if0.coin_accept), tbl[i].acc);
            chk($sformatf("tbl%0d_reject", i), int'(if0.coin_reject), tbl[i].rej);
            chk($sformatf("tbl%0d_err", i), int'(if0.err_insuf), tbl[i].err);
            chk($sformatf("tbl%0d_vvalid", i), int'(if0.vend_valid), tbl[i].vv);
            chk($sformatf("tbl%0d_vid", i), int'(if0.vend_id), tbl[i].vid);
            chk($sformatf("tbl%0d_cvalid", i), int'(if0.chg_valid), tbl[i].cvld);
            chk($sformatf("tbl%0d_busy", i), int'(if0.busy), tbl[i].busy);
        end

        // Cancel refund with a stalling dispenser
        reset = 1'b1; step(0, 0, 0, 0, 0, 0, 0); reset = 1'b0;
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("chg_pre_credit", int'(if0.credit), 3);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("chg_start_credit", int'(if0.credit), 3);
        chk("chg_start_cvalid", int'(if0.chg_valid), 1);
        chk("chg_start_busy", int'(if0.busy), 1);
        beats = 0;
        begin
            int pat [4] = '{1, 0, 1, 1};
            int exp_cr [4] = '{2, 2, 1, 0};
            for (int i = 0; i < 4; i++) begin
                if (if0.chg_valid && pat[i] == 1) beats++;
                step(0, 0, 0, 0, 0, 0, pat[i]);
                chk($sformatf("chg_beat%0d_credit", i), int'(if0.credit), exp_cr[i]);
            end
        end
        chk("chg_beats", beats, 3);
        chk("chg_end_busy", int'(if0.busy), 0);
        chk("chg_end_cvalid", int'(if0.chg_valid), 0);

        // Automatic change after vend on the refunding instance
        reset = 1'b1; step(0, 0, 0, 0, 0, 0, 0); reset = 1'b0;
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("auto_credit5", int'(if1.credit), 5);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("auto_vvalid", int'(if1.vend_valid), 1);
        chk("auto_vid", int'(if1.vend_id), 0);
        chk("auto_vend_credit", int'(if1.credit), 3);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("auto_to_chg_cvalid", int'(if1.chg_valid), 1);
        chk("auto_to_chg_vvalid", int'(if1.vend_valid), 0);
        chk("keep_credit_dut0", int'(if0.credit), 3);
        chk("keep_busy_dut0", int'(if0.busy), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("auto_beat%0d_credit", i), int'(if1.credit), 2 - i);
        end
        chk("auto_end_busy", int'(if1.busy), 0);
        chk("auto_end_cvalid", int'(if1.chg_valid), 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        chk("cancel_wins_cvalid", int'(if1.chg_valid), 1);
        chk("cancel_wins_vvalid", int'(if1.vend_valid), 0);
        chk("cancel_wins_credit", int'(if1.credit), 2);

        // Reset mid-refund
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("midrst_cvalid", int'(if1.chg_valid), 0);
        chk("midrst_credit", int'(if1.credit), 0);
        chk("midrst_busy", int'(if1.busy), 0);
        chk("midrst_pulses", int'(if1.coin_accept) + int'(if1.coin_reject) + int'(if1.err_insuf) + int'(if1.vend_valid), 0);

        // Randomised traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
